ext_bus_sequencer: RTL and testbench

//  Downstream of the CPU address translator. Takes one translated 20-bit bus request per CPU cycle and runs it on the async external SRAM/ROM bus.

---
 rtl/ext_bus_pkg.sv | 23 ++
 rtl/ext_bus_if.sv | 33 +++
 rtl/ext_bus_ws_counter.sv | 32 +++
 rtl/ext_bus_sequencer.sv | 159 +++++++++++++++
 tb/tb_ext_bus_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/ext_bus_pkg.sv
// Shared encodings and helpers for the external SRAM/ROM bus sequencer.
package ext_bus_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StSetup  = 2'd1;
  localparam state_t StStrobe = 2'd2;
  localparam state_t StHold   = 2'd3;

  localparam logic [19:0] RomSize  = 20'h800;
  localparam logic [3:0]  PageMask = 4'hF;

  // Page 0 of the 1 MiB space is RAM; every other page is ROM/IO.
  function automatic logic region_is_ram(input logic [19:0] addr);
    return (addr[19:16] & PageMask) == 4'h0;
  endfunction

  function automatic logic in_rom_window(input logic [19:0] addr, input logic [19:0] base);
    return (addr >= base) && (addr <= base + (RomSize - 20'd1));
  endfunction

endpackage

// File: rtl/ext_bus_if.sv
// CPU request/response and external memory bus signals of the sequencer.
interface ext_bus_if;

  logic        cpu_req;
  logic [19:0] addr_ext;
  logic        cpu_rw;
  logic [7:0]  cpu_wdata;
  logic        cpu_mrdy;
  logic [7:0]  cpu_rdata;
  logic        rdata_valid;
  logic        overrun;
  logic        wp_err;
  logic [19:0] mem_addr;
  logic [7:0]  mem_dq_in;
  logic [7:0]  mem_dq_out;
  logic        mem_dq_oe;
  logic        mem_ce_n;
  logic        mem_oe_n;
  logic        mem_we_n;

  modport master (
    input  cpu_req, addr_ext, cpu_rw, cpu_wdata, mem_dq_in,
    output cpu_mrdy, cpu_rdata, rdata_valid, overrun, wp_err,
    output mem_addr, mem_dq_out, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n
  );

  modport slave (
    output cpu_req, addr_ext, cpu_rw, cpu_wdata, mem_dq_in,
    input  cpu_mrdy, cpu_rdata, rdata_valid, overrun, wp_err,
    input  mem_addr, mem_dq_out, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n
  );

endinterface

// File: rtl/ext_bus_ws_counter.sv
// Wait-state counter: load, then decrement to zero and stop there.
module ext_bus_ws_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/ext_bus_sequencer.sv
// Runs one CPU request on the async external bus with per-region wait states.
// Optional write protection of the boot-ROM window: EXT_BUS_WRITE_PROTECT_EN.
module ext_bus_sequencer
  import ext_bus_pkg::*;
#(
  parameter logic [3:0]  WS_LO    = 4'd1,
  parameter logic [3:0]  WS_HI    = 4'd3,
  parameter logic [19:0] ROM_BASE = 20'h10800
) (
  input logic         clk,
  input logic         rst,
  ext_bus_if.master   bus
);

`ifdef EXT_BUS_WRITE_PROTECT_EN
  localparam bit WpEn = 1'b1;
`else
  localparam bit WpEn = 1'b0;
`endif

  state_t      state_q, state_d;
  logic        rw_q, rw_d;
  logic [3:0]  ws_q, ws_d;
  logic        wp_q, wp_d;
  logic [19:0] mem_addr_q, mem_addr_d;
  logic [7:0]  dq_out_q, dq_out_d;
  logic        dq_oe_q, dq_oe_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        mrdy_q, mrdy_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic        overrun_q, overrun_d;
  logic        wp_err_q, wp_err_d;
  logic        cnt_zero;
  logic        wp_hit;

  ext_bus_ws_counter u_ws_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q == StSetup),
    .load_val_i (ws_q),
    .dec_i      (state_q == StStrobe),
    .zero_o     (cnt_zero)
  );

  assign wp_hit = WpEn & ~bus.cpu_rw & in_rom_window(bus.addr_ext, ROM_BASE);

  always_comb begin
    state_d       = state_q;
    rw_d          = rw_q;
    ws_d          = ws_q;
    wp_d          = wp_q;
    mem_addr_d    = mem_addr_q;
    dq_out_d      = dq_out_q;
    dq_oe_d       = dq_oe_q;
    ce_n_d        = ce_n_q;
    oe_n_d        = oe_n_q;
    we_n_d        = we_n_q;
    mrdy_d        = mrdy_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    wp_err_d      = 1'b0;
    // A request landing on the HOLD->IDLE edge is still treated as busy.
    overrun_d     = overrun_q | (bus.cpu_req & (state_q != StIdle));

    case (state_q)
      StIdle: begin
        if (bus.cpu_req) begin
          state_d    = StSetup;
          rw_d       = bus.cpu_rw;
          ws_d       = region_is_ram(bus.addr_ext) ? WS_LO : WS_HI;
          wp_d       = wp_hit;
          mem_addr_d = bus.addr_ext;
          ce_n_d     = 1'b0;
          mrdy_d     = 1'b0;
          dq_oe_d    = ~bus.cpu_rw & ~wp_hit;
          if (!bus.cpu_rw) begin
            dq_out_d = bus.cpu_wdata;
          end
        end
      end
      StSetup: begin
        state_d = StStrobe;
        oe_n_d  = ~rw_q;
        we_n_d  = rw_q | wp_q;
      end
      StStrobe: begin
        if (cnt_zero) begin
          state_d  = StHold;
          oe_n_d   = 1'b1;
          we_n_d   = 1'b1;
          wp_err_d = wp_q;
          if (rw_q) begin
            rdata_d       = bus.mem_dq_in;
            rdata_valid_d = 1'b1;
          end
        end
      end
      StHold: begin
        state_d = StIdle;
        mrdy_d  = 1'b1;
        ce_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      rw_q          <= 1'b1;
      ws_q          <= 4'd0;
      wp_q          <= 1'b0;
      mem_addr_q    <= 20'd0;
      dq_out_q      <= 8'd0;
      dq_oe_q       <= 1'b0;
      ce_n_q        <= 1'b1;
      oe_n_q        <= 1'b1;
      we_n_q        <= 1'b1;
      mrdy_q        <= 1'b1;
      rdata_q       <= 8'd0;
      rdata_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      wp_err_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      rw_q          <= rw_d;
      ws_q          <= ws_d;
      wp_q          <= wp_d;
      mem_addr_q    <= mem_addr_d;
      dq_out_q      <= dq_out_d;
      dq_oe_q       <= dq_oe_d;
      ce_n_q        <= ce_n_d;
      oe_n_q        <= oe_n_d;
      we_n_q        <= we_n_d;
      mrdy_q        <= mrdy_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      overrun_q     <= overrun_d;
      wp_err_q      <= wp_err_d;
    end
  end

  assign bus.cpu_mrdy    = mrdy_q;
  assign bus.cpu_rdata   = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.overrun     = overrun_q;
  assign bus.wp_err      = wp_err_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_dq_out  = dq_out_q;
  assign bus.mem_dq_oe   = dq_oe_q;
  assign bus.mem_ce_n    = ce_n_q;
  assign bus.mem_oe_n    = oe_n_q;
  assign bus.mem_we_n    = we_n_q;

endmodule

// File: tb/tb_ext_bus_sequencer.sv
// Directed bench for ext_bus_sequencer: dut0 uses WS_HI=3, dut1 uses WS_HI=0.
module tb_ext_bus_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ext_bus_if bus0 ();
  ext_bus_if bus1 ();

  ext_bus_sequencer #(
    .WS_LO    (4'd1),
    .WS_HI    (4'd3),
    .ROM_BASE (20'h10800)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  ext_bus_sequencer #(
    .WS_LO    (4'd1),
    .WS_HI    (4'd0),
    .ROM_BASE (20'h10800)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int mrdy_lo, ce_lo, oe_lo, we_lo, dqoe_cnt, out_bad, addr_bad, both_lo;
  int rv_cnt, rv_at, wp_cnt, wp_at;
  logic [7:0] rdata_last;
  logic       ovr_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic req, input logic [19:0] a, input logic rw,
                       input logic [7:0] wd, input logic [7:0] dqin);
    bus0.cpu_req   = sel ? 1'b0 : req;
    bus1.cpu_req   = sel ? req : 1'b0;
    bus0.addr_ext  = a;
    bus1.addr_ext  = a;
    bus0.cpu_rw    = rw;
    bus1.cpu_rw    = rw;
    bus0.cpu_wdata = wd;
    bus1.cpu_wdata = wd;
    bus0.mem_dq_in = dqin;
    bus1.mem_dq_in = dqin;
  endtask

  // Issue one request at edge N and profile the 10 cycles after it (sample i = after edge N+i).
  task automatic access(input bit sel, input logic [19:0] a, input logic rw, input logic [7:0] wd,
                        input logic [7:0] dqin, input int extra_at);
    logic mrdy, ce_n, oe_n, we_n, dq_oe, rv, wpe;
    logic [7:0] dq_out;
    logic [19:0] maddr;
    mrdy_lo = 0; ce_lo = 0; oe_lo = 0; we_lo = 0; dqoe_cnt = 0; out_bad = 0; addr_bad = 0;
    both_lo = 0; rv_cnt = 0; rv_at = -1; wp_cnt = 0; wp_at = -1;
    drive(sel, 1'b1, a, rw, wd, dqin);
    step;
    drive(sel, 1'b0, a, rw, wd, dqin);
    for (int i = 0; i < 10; i++) begin
      mrdy   = sel ? bus1.cpu_mrdy    : bus0.cpu_mrdy;
      ce_n   = sel ? bus1.mem_ce_n    : bus0.mem_ce_n;
      oe_n   = sel ? bus1.mem_oe_n    : bus0.mem_oe_n;
      we_n   = sel ? bus1.mem_we_n    : bus0.mem_we_n;
      dq_oe  = sel ? bus1.mem_dq_oe   : bus0.mem_dq_oe;
      rv     = sel ? bus1.rdata_valid : bus0.rdata_valid;
      wpe    = sel ? bus1.wp_err      : bus0.wp_err;
      dq_out = sel ? bus1.mem_dq_out  : bus0.mem_dq_out;
      maddr  = sel ? bus1.mem_addr    : bus0.mem_addr;
      if (!mrdy) mrdy_lo++;
      if (!ce_n) ce_lo++;
      if (!oe_n) oe_lo++;
      if (!we_n) we_lo++;
      if (!oe_n && !we_n) both_lo++;
      if (dq_oe) dqoe_cnt++;
      if (dq_oe && (dq_out !== wd)) out_bad++;
      if (!ce_n && (maddr !== a)) addr_bad++;
      if (rv) begin rv_cnt++; rv_at = i; end
      if (wpe) begin wp_cnt++; wp_at = i; end
      if (extra_at >= 1 && i == extra_at - 1) drive(sel, 1'b1, 20'h00FFF, 1'b1, 8'h00, dqin);
      step;
      drive(sel, 1'b0, a, rw, wd, dqin);
    end
    rdata_last = sel ? bus1.cpu_rdata : bus0.cpu_rdata;
    ovr_last   = sel ? bus1.overrun   : bus0.overrun;
  endtask

  initial begin
    drive(1'b0, 1'b0, 20'h0, 1'b1, 8'h00, 8'h00);
    rst = 1'b1;
    step;
    step;

    chk("rst_mrdy",    32'(bus0.cpu_mrdy), 32'd1);
    chk("rst_ce_n",    32'(bus0.mem_ce_n), 32'd1);
    chk("rst_oe_n",    32'(bus0.mem_oe_n), 32'd1);
    chk("rst_we_n",    32'(bus0.mem_we_n), 32'd1);
    chk("rst_dq_oe",   32'(bus0.mem_dq_oe), 32'd0);
    chk("rst_addr",    32'(bus0.mem_addr), 32'd0);
    chk("rst_dq_out",  32'(bus0.mem_dq_out), 32'd0);
    chk("rst_rdata",   32'(bus0.cpu_rdata), 32'd0);
    chk("rst_rv",      32'(bus0.rdata_valid), 32'd0);
    chk("rst_overrun", 32'(bus0.overrun), 32'd0);
    chk("rst_wp_err",  32'(bus0.wp_err), 32'd0);

    rst = 1'b0;
    step;

    // RAM read, WS_LO=1.
    access(1'b0, 20'h01234, 1'b1, 8'h00, 8'hA5, 0);
    chk("rd0_mrdy_lo", mrdy_lo, 32'd4);
    chk("rd0_ce_lo",   ce_lo, 32'd4);
    chk("rd0_oe_lo",   oe_lo, 32'd2);
    chk("rd0_we_lo",   we_lo, 32'd0);
    chk("rd0_dqoe",    dqoe_cnt, 32'd0);
    chk("rd0_rv_cnt",  rv_cnt, 32'd1);
    chk("rd0_rv_at",   rv_at, 32'd3);
    chk("rd0_rdata",   32'(rdata_last), 32'hA5);
    chk("rd0_addr",    addr_bad, 32'd0);

    // RAM write, WS_LO=1.
    access(1'b0, 20'h00010, 1'b0, 8'h3C, 8'hEE, 0);
    chk("wr0_we_lo",   we_lo, 32'd2);
    chk("wr0_oe_lo",   oe_lo, 32'd0);
    chk("wr0_dqoe",    dqoe_cnt, 32'd4);
    chk("wr0_dq_out",  out_bad, 32'd0);
    chk("wr0_mrdy_lo", mrdy_lo, 32'd4);
    chk("wr0_rv_cnt",  rv_cnt, 32'd0);
    chk("wr0_rdata",   32'(rdata_last), 32'hA5);
    chk("wr0_addr",    addr_bad, 32'd0);

    // ROM page read, WS_HI=3.
    access(1'b0, 20'h10100, 1'b1, 8'h00, 8'h5A, 0);
    chk("rd1_oe_lo",   oe_lo, 32'd4);
    chk("rd1_mrdy_lo", mrdy_lo, 32'd6);
    chk("rd1_rv_at",   rv_at, 32'd5);
    chk("rd1_rdata",   32'(rdata_last), 32'h5A);

    // Same read with WS_HI=0.
    access(1'b1, 20'h10100, 1'b1, 8'h00, 8'hC3, 0);
    chk("rd2_oe_lo",   oe_lo, 32'd1);
    chk("rd2_mrdy_lo", mrdy_lo, 32'd3);
    chk("rd2_rv_at",   rv_at, 32'd2);
    chk("rd2_rdata",   32'(rdata_last), 32'hC3);
    chk("rd2_both_lo", both_lo, 32'd0);

    // Second request at N+2 is dropped; first access timing unchanged.
    access(1'b0, 20'h00020, 1'b1, 8'h00, 8'h96, 2);
    chk("ovr_mrdy_lo", mrdy_lo, 32'd4);
    chk("ovr_oe_lo",   oe_lo, 32'd2);
    chk("ovr_rv_cnt",  rv_cnt, 32'd1);
    chk("ovr_rdata",   32'(rdata_last), 32'h96);
    chk("ovr_flag",    32'(ovr_last), 32'd1);
    step;
    step;
    chk("ovr_sticky",  32'(bus0.overrun), 32'd1);
    chk("ovr_idle",    32'(bus0.cpu_mrdy), 32'd1);

    // Write into the boot-ROM window.
    access(1'b0, 20'h10900, 1'b0, 8'h42, 8'h00, 0);
    chk("wp_mrdy_lo",  mrdy_lo, 32'd6);
    chk("wp_oe_lo",    oe_lo, 32'd0);
`ifdef EXT_BUS_WRITE_PROTECT_EN
    chk("wp_we_lo",    we_lo, 32'd0);
    chk("wp_dqoe",     dqoe_cnt, 32'd0);
    chk("wp_err_cnt",  wp_cnt, 32'd1);
    chk("wp_err_at",   wp_at, 32'd5);
`else
    chk("wp_we_lo",    we_lo, 32'd4);
    chk("wp_dqoe",     dqoe_cnt, 32'd6);
    chk("wp_err_cnt",  wp_cnt, 32'd0);
    chk("wp_dq_out",   out_bad, 32'd0);
`endif

    // Reset in the middle of a write strobe.
    drive(1'b0, 1'b1, 20'h00040, 1'b0, 8'h77, 8'h00);
    step;
    drive(1'b0, 1'b0, 20'h00040, 1'b0, 8'h77, 8'h00);
    step;
    chk("mid_we_lo",   32'(bus0.mem_we_n), 32'd0);
    rst = 1'b1;
    step;
    chk("mid_we_n",    32'(bus0.mem_we_n), 32'd1);
    chk("mid_ce_n",    32'(bus0.mem_ce_n), 32'd1);
    chk("mid_oe_n",    32'(bus0.mem_oe_n), 32'd1);
    chk("mid_mrdy",    32'(bus0.cpu_mrdy), 32'd1);
    chk("mid_dq_oe",   32'(bus0.mem_dq_oe), 32'd0);
    chk("mid_overrun", 32'(bus0.overrun), 32'd0);
    rst = 1'b0;
    step;

    // Back in IDLE: a fresh read must run normally.
    access(1'b0, 20'h00050, 1'b1, 8'h00, 8'h11, 0);
    chk("post_mrdy_lo", mrdy_lo, 32'd4);
    chk("post_rv_at",   rv_at, 32'd3);
    chk("post_rdata",   32'(rdata_last), 32'h11);
    chk("post_overrun", 32'(ovr_last), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
